// File: rtl/kara_pkg.sv
// rtl/kara_pkg.sv - shared state, step-schedule constants and defaults for karatsuba_lower_seq
package kara_pkg;

  localparam int N_DEF = 32;
  localparam int K_DEF = 4;
  localparam int M_DEF = 8;

  typedef enum logic [1:0] {IDLE, MUL, COMB, DONE} state_t;

  typedef enum logic [1:0] {DST_G0, DST_G1, DST_G2} dst_t;

  // Bit s set: the product of step s carries weight r^2 (steps 1,2,4,5,7,8).
  localparam logic [15:0] STEP_HI = 16'h01B6;

  // Steps 0-2 feed G0, 3-5 feed G1, 6-8 feed G2.
  function automatic dst_t step_dst(input logic [3:0] s);
    if (s < 4'd3) return DST_G0;
    else if (s < 4'd6) return DST_G1;
    return DST_G2;
  endfunction

  function automatic logic step_hi(input logic [3:0] s);
    return STEP_HI[s];
  endfunction

endpackage

// File: rtl/karatsuba_lower_seq_booth.sv
// rtl/karatsuba_lower_seq_booth.sv - radix-4 Booth multiplier (module booth), W-bit signed operands
module booth #(
  parameter int W  = 10,
  parameter int PW = 20
) (
  input  logic [W-1:0]  x,
  input  logic [W-1:0]  y,
  output logic [PW-1:0] p
);

  logic [PW-1:0] xs;
  logic [PW-1:0] pp;
  logic [W:0]    yb;
  logic [2:0]    dig;

  // Operands arrive zero-extended, so the signed product equals the unsigned one.
  always_comb begin
    xs  = {{(PW-W){x[W-1]}}, x};
    yb  = {y, 1'b0};
    p   = '0;
    pp  = '0;
    dig = '0;
    for (int i = 0; i < W/2; i++) begin
      dig = yb[2*i +: 3];
      case (dig)
        3'b001, 3'b010: pp = xs;
        3'b011:         pp = xs << 1;
        3'b100:         pp = -(xs << 1);
        3'b101, 3'b110: pp = -xs;
        default:        pp = '0;
      endcase
      p = p + (pp << (2*i));
    end
  end

endmodule

// File: rtl/karatsuba_lower_seq.sv
// rtl/karatsuba_lower_seq.sv - one-multiplier sequencer for the lower Karatsuba product; KARA_SEQ_PIPE_EN adds a product register
module karatsuba_lower_seq
  import kara_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int K = K_DEF,
  parameter int M = M_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] out,
  output logic           busy
);

  localparam int BW = M + 2;
  localparam int PW = 2*M + 4;
  localparam int W2 = 2*N;
`ifdef KARA_SEQ_PIPE_EN
  localparam logic [3:0] LAST_STEP = 4'd9;
`else
  localparam logic [3:0] LAST_STEP = 4'd8;
`endif

  if ((N / K != M) || (K != 4)) begin : g_bad_cfg
    $error("karatsuba_lower_seq: need K == 4 and N/K == M");
  end

  state_t        state, state_nx;
  logic [3:0]    step;
  logic [N-1:0]  a_q, b_q;
  logic [W2-1:0] g0, g1, g2, p11, out_q, comb_val;
  logic [M-1:0]  a0, a1, a2, a3, b0, b1, b2, b3;
  logic [M:0]    sa01, sa23, sb01, sb23;
  logic [BW-1:0] op_x, op_y;
  logic [PW-1:0] prod;
  logic          acc_en;
  logic [3:0]    acc_step;
  logic [W2-1:0] acc_prod, acc_term;

  assign a0 = a_q[0 +: M];
  assign a1 = a_q[M +: M];
  assign a2 = a_q[2*M +: M];
  assign a3 = a_q[3*M +: M];
  assign b0 = b_q[0 +: M];
  assign b1 = b_q[M +: M];
  assign b2 = b_q[2*M +: M];
  assign b3 = b_q[3*M +: M];
  assign sa01 = {1'b0, a0} + {1'b0, a1};
  assign sa23 = {1'b0, a2} + {1'b0, a3};
  assign sb01 = {1'b0, b0} + {1'b0, b1};
  assign sb23 = {1'b0, b2} + {1'b0, b3};

  always_comb begin
    op_x = '0;
    op_y = '0;
    case (step)
      4'd0: begin op_x = {2'b00, a0}; op_y = {2'b00, b0}; end
      4'd1: begin op_x = {2'b00, a2}; op_y = {2'b00, b0}; end
      4'd2: begin op_x = {2'b00, a0}; op_y = {2'b00, b2}; end
      4'd3: begin op_x = {1'b0, sa01}; op_y = {1'b0, sb01}; end
      4'd4: begin op_x = {1'b0, sa23}; op_y = {1'b0, sb01}; end
      4'd5: begin op_x = {1'b0, sa01}; op_y = {1'b0, sb23}; end
      4'd6: begin op_x = {2'b00, a1}; op_y = {2'b00, b1}; end
      4'd7: begin op_x = {2'b00, a3}; op_y = {2'b00, b1}; end
      4'd8: begin op_x = {2'b00, a1}; op_y = {2'b00, b3}; end
      default: ;
    endcase
  end

  booth #(.W(BW), .PW(PW)) u_booth (
    .x (op_x),
    .y (op_y),
    .p (prod)
  );

`ifdef KARA_SEQ_PIPE_EN
  logic          pv_q;
  logic [3:0]    pstep_q;
  logic [PW-1:0] prod_q;

  // Step LAST_STEP is the drain cycle: nothing is issued, the step-8 product lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv_q    <= 1'b0;
      pstep_q <= '0;
      prod_q  <= '0;
    end else begin
      pv_q    <= (state == MUL) && (step != LAST_STEP);
      pstep_q <= step;
      prod_q  <= prod;
    end
  end

  assign acc_en   = pv_q;
  assign acc_step = pstep_q;
  assign acc_prod = {{(W2-PW){1'b0}}, prod_q};
`else
  assign acc_en   = (state == MUL);
  assign acc_step = step;
  assign acc_prod = {{(W2-PW){1'b0}}, prod};
`endif

  assign acc_term = step_hi(acc_step) ? (acc_prod << (2*M)) : acc_prod;
  assign comb_val = ((g1 - g2 - g0) << M) + g0 + (p11 << (2*M));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      step  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      g0    <= '0;
      g1    <= '0;
      g2    <= '0;
      p11   <= '0;
      out_q <= '0;
    end else begin
      state <= state_nx;
      if (acc_en) begin
        case (step_dst(acc_step))
          DST_G0:  g0 <= g0 + acc_term;
          DST_G1:  g1 <= g1 + acc_term;
          DST_G2:  g2 <= g2 + acc_term;
          default: ;
        endcase
        if (acc_step == 4'd6) p11 <= acc_prod;
      end
      case (state)
        IDLE: if (in_valid) begin
          a_q  <= a;
          b_q  <= b;
          g0   <= '0;
          g1   <= '0;
          g2   <= '0;
          p11  <= '0;
          step <= '0;
        end
        MUL:     step <= (step == LAST_STEP) ? 4'd0 : step + 4'd1;
        COMB:    out_q <= comb_val;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        in_ready = rst_n;
        busy     = 1'b0;
        if (in_valid) state_nx = MUL;
      end
      MUL:  if (step == LAST_STEP) state_nx = COMB;
      COMB: state_nx = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign out = out_q;

endmodule

// File: tb/tb_karatsuba_lower_seq.sv
// tb/tb_karatsuba_lower_seq.sv - self-checking bench for karatsuba_lower_seq against a limb-sum model
module tb_karatsuba_lower_seq;

`ifdef KARA_SEQ_PIPE_EN
  localparam int LAT = 12;
`else
  localparam int LAT = 11;
`endif

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out;
  logic        busy;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_q[$];

  karatsuba_lower_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a_in),
    .b         (b_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Lower partial product: every limb pair whose weight r^(i+j) stays at or below r^3.
  function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y);
    logic [63:0] s;
    s = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        if (i + j <= 3)
          s = s + ((64'(x[8*i +: 8]) * 64'(y[8*j +: 8])) << (8*(i+j)));
    return s;
  endfunction

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic checkint(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic compare_loop();
    int   ncount = 0;
    int   hs_at = 0;
    logic ov_prev = 1'b0;
    forever begin
      @(negedge clk);
      ncount++;
      if (!rst_n) begin
        check1("rst_in_ready", in_ready, 1'b0);
        check1("rst_out_valid", out_valid, 1'b0);
        check1("rst_busy", busy, 1'b0);
        check64("rst_out", out, 64'h0);
        exp_q.delete();
        ov_prev = 1'b0;
      end else begin
        check1("ready_vs_busy", in_ready, !busy);
        if (out_valid) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_out_valid: got 1 expected 0");
          end else begin
            check64("model_out", out, exp_q[0]);
            if (!ov_prev) checkint("latency", ncount - hs_at, LAT);
            if (out_ready) void'(exp_q.pop_front());
          end
        end
        if (in_valid && in_ready) begin
          exp_q.push_back(model(a_in, b_in));
          hs_at = ncount;
        end
        ov_prev = out_valid;
      end
    end
  endtask

  task automatic run_job(input logic [31:0] x, input logic [31:0] y,
                         input logic [63:0] exp, input int hold);
    bit ok;
    @(posedge clk); #1;
    in_valid  = 1'b1;
    a_in      = x;
    b_in      = y;
    out_ready = (hold == 0);
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin checks++; errors++; $display("FAIL handshake_timeout: got none expected in_ready"); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    a_in     = ~x;
    b_in     = $urandom;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL out_valid_timeout: got none expected out_valid");
      return;
    end
    check64("job_out", out, exp);
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        if (i > 0) @(negedge clk);
        check64("bp_out_stable", out, exp);
        check1("bp_in_ready", in_ready, 1'b0);
        check1("bp_out_valid", out_valid, 1'b1);
        if (i == 1) begin
          @(posedge clk); #1;
          in_valid = 1'b1;
          a_in     = 32'hDEAD_BEEF;
          b_in     = 32'h1234_5678;
        end
      end
      @(posedge clk); #1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      check1("bp_last_valid", out_valid, 1'b1);
      check64("bp_last_out", out, exp);
    end
    @(negedge clk);
    check1("done_one_cycle", out_valid, 1'b0);
    check1("idle_in_ready", in_ready, 1'b1);
  endtask

  task automatic run_tests();
    logic [31:0] x, y;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a_in      = '0;
    b_in      = '0;
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check1("post_rst_in_ready", in_ready, 1'b1);
    check1("post_rst_busy", busy, 1'b0);
    check1("post_rst_out_valid", out_valid, 1'b0);
    check64("post_rst_out", out, 64'h0);

    check64("model_1x1", model(32'h1, 32'h1), 64'h1);
    check64("model_r_r", model(32'h100, 32'h100), 64'h10000);
    check64("model_r2_1", model(32'h10000, 32'h1), 64'h10000);
    check64("model_r3_r", model(32'h0100_0000, 32'h100), 64'h0);
    check64("model_ones", model(32'hFFFF_FFFF, 32'hFFFF_FFFF), 64'h0000_03FB_0000_0001);

    run_job(32'h1, 32'h1, 64'h1, 0);
    run_job(32'h100, 32'h100, 64'h10000, 0);
    run_job(32'h10000, 32'h1, 64'h10000, 0);
    run_job(32'h0100_0000, 32'h100, 64'h0, 0);
    run_job(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_03FB_0000_0001, 5);
    for (int k = 0; k < 4; k++) begin
      x = $urandom;
      y = $urandom;
      run_job(x, y, model(x, y), k);
    end

    // Reset at MUL step 4: handshake cycle plus five cycles.
    @(posedge clk); #1;
    in_valid = 1'b1;
    a_in     = 32'h0505_0505;
    b_in     = 32'h0707_0707;
    @(negedge clk);
    check1("rst_job_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    #2;
    rst_n = 1'b0;
    @(negedge clk);
    check1("midrst_out_valid", out_valid, 1'b0);
    check1("midrst_in_ready", in_ready, 1'b0);
    check1("midrst_busy", busy, 1'b0);
    check64("midrst_out", out, 64'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_job(32'h1, 32'h1, 64'h1, 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    fork
      compare_loop();
      run_tests();
    join_any
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
